// File: rtl/muldiv_pkg.sv
// Shared RV32M constants: funct3 op codes and the sequencer state encoding.
// The decoder reuses the MD_* codes to detect M-extension ops.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_unit.sv
// Iterative datapath on unsigned magnitudes: one shift-add multiply step or one
// restoring-divide step per cycle. {hi,lo} is the product, or {remainder,quotient}.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a_val,
    input  logic [DATA_WIDTH-1:0] b_val,
    output logic [DATA_WIDTH-1:0] step_hi,
    output logic [DATA_WIDTH-1:0] step_lo
);

    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_diff;

    // The step result is exported so the sequencer can sign-fix the final step
    // in the same cycle it is computed.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        rem_shift = {hi, lo[DATA_WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        if (is_div) begin
            if (!rem_diff[DATA_WIDTH]) begin
                {step_hi, step_lo} = {rem_diff[DATA_WIDTH-1:0], lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                {step_hi, step_lo} = {rem_shift[DATA_WIDTH-1:0], lo[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            {step_hi, step_lo} = {mul_sum, lo[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            b_q <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a_val;
            b_q <= b_val;
        end else if (step) begin
            hi <= step_hi;
            lo <= step_lo;
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: accepts an M-op, stalls the front end, returns the result.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module ex_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [2:0]                     funct3_i,
    input  logic [DATA_WIDTH-1:0]          rs1_val_i,
    input  logic [DATA_WIDTH-1:0]          rs2_val_i,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_i,
    input  logic                           flush_i,
    output logic                           stall_EX_o,
    output logic                           done_o,
    output logic [DATA_WIDTH-1:0]          result_o,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_o,
    output logic                           busy_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    state_t                         state, state_next;
    logic [CW-1:0]                  count, count_next;
    logic [2:0]                     funct3_q;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_q;
    logic                           sign_q, a_neg_q;
    logic [DATA_WIDTH-1:0]          result_q, result_next;
    logic                           load, step, accept;

    logic                    is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic                    div_zero, div_ovf, mul_fast;
    logic [DATA_WIDTH-1:0]   a_mag, b_mag, div_fast_res, mul_fast_res, calc_res;
    logic [DATA_WIDTH-1:0]   step_hi, step_lo, quot_fix, rem_fix;
    logic [2*DATA_WIDTH-1:0] prod_fix;

    // MULHSU: rs1 signed, rs2 unsigned; DIVU/REMU (funct3[0]=1) unsigned.
    assign is_div_in   = funct3_i[2];
    assign a_signed_in = is_div_in ? ~funct3_i[0] : (funct3_i != MD_MULHU);
    assign b_signed_in = is_div_in ? ~funct3_i[0] : (funct3_i == MD_MUL || funct3_i == MD_MULH);
    assign a_neg_in    = a_signed_in & rs1_val_i[DATA_WIDTH-1];
    assign b_neg_in    = b_signed_in & rs2_val_i[DATA_WIDTH-1];
    assign a_mag       = a_neg_in ? -rs1_val_i : rs1_val_i;
    assign b_mag       = b_neg_in ? -rs2_val_i : rs2_val_i;

    assign div_zero = is_div_in && (rs2_val_i == '0);
    assign div_ovf  = is_div_in && !funct3_i[0] && (rs2_val_i == '1) &&
                      (rs1_val_i == {1'b1, {(DATA_WIDTH-1){1'b0}}});
    assign div_fast_res = div_zero ? (funct3_i[1] ? rs1_val_i : '1)
                                   : (funct3_i[1] ? '0 : rs1_val_i);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*DATA_WIDTH+1:0] fast_prod;
    assign fast_prod    = $signed({a_neg_in, rs1_val_i}) * $signed({b_neg_in, rs2_val_i});
    assign mul_fast     = !is_div_in;
    assign mul_fast_res = (funct3_i == MD_MUL) ? fast_prod[DATA_WIDTH-1:0]
                                               : fast_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`else
    assign mul_fast     = 1'b0;
    assign mul_fast_res = '0;
`endif

    muldiv_iter_unit #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .is_div  (funct3_q[2]),
        .a_val   (a_mag),
        .b_val   (b_mag),
        .step_hi (step_hi),
        .step_lo (step_lo)
    );

    // Remainder follows the dividend sign; quotient/product follow the xor of signs.
    assign prod_fix = sign_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign quot_fix = sign_q ? -step_lo : step_lo;
    assign rem_fix  = a_neg_q ? -step_hi : step_hi;
    assign calc_res = funct3_q[2] ? (funct3_q[1] ? rem_fix : quot_fix)
                                  : ((funct3_q == MD_MUL) ? prod_fix[DATA_WIDTH-1:0]
                                                          : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH]);

    assign accept = (state == ST_IDLE) && start_i && !flush_i;

    always_comb begin
        state_next  = state;
        count_next  = count;
        result_next = result_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (div_zero || div_ovf) begin
                        result_next = div_fast_res;
                        state_next  = ST_DONE;
                    end else if (mul_fast) begin
                        result_next = mul_fast_res;
                        state_next  = ST_DONE;
                    end else begin
                        load       = 1'b1;
                        count_next = CW'(DATA_WIDTH - 1);
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (count == '0) begin
                    result_next = calc_res;
                    state_next  = ST_DONE;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            state_next  = ST_IDLE;
            count_next  = '0;
            result_next = result_q;
            load        = 1'b0;
            step        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            sign_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            result_q <= result_next;
            if (accept) begin
                funct3_q <= funct3_i;
                rd_q     <= rd_i;
                sign_q   <= a_neg_in ^ b_neg_in;
                a_neg_q  <= a_neg_in;
            end
        end
    end

    assign stall_EX_o = start_i && (state != ST_DONE) && !flush_i;
    assign done_o     = (state == ST_DONE) && !flush_i;
    assign result_o   = (state == ST_DONE) ? result_q : '0;
    assign rd_o       = rd_q;
    assign busy_o     = (state != ST_IDLE);

    // EX must hold the op for as long as the engine is iterating.
    start_held_in_calc: assert property (@(posedge clk) disable iff (rst)
        (state == ST_CALC && !flush_i) |-> start_i);

endmodule
